// File: rtl/data_mem_arbiter.sv
// Single-port data memory arbiter: CPU port A plus an internal dump sequencer (port B).
// Optional macro DATA_MEM_ARB_RR_EN: alternate winners on contention instead of fixed A priority.
module data_mem_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_a_req,
    input  logic              i_a_wr,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_wdata,
    output logic              o_a_gnt,
    output logic              o_a_rvalid,
    output logic [DATA_W-1:0] o_a_rdata,
    input  logic              i_dump_start,
    input  logic [ADDR_W-1:0] i_dump_base,
    input  logic [ADDR_W:0]   i_dump_len,
    output logic [DATA_W-1:0] o_dump_data,
    output logic              o_dump_valid,
    input  logic              i_dump_ready,
    output logic              o_dump_busy,
    output logic              o_dump_done,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_wr,
    output logic              o_mem_rd,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   issued_q, issued_d;
    logic [ADDR_W:0]   accepted_q, accepted_d;
    logic              dump_valid_q, dump_valid_d;
    logic [DATA_W-1:0] dump_data_q, dump_data_d;
    logic              a_rvalid_q, a_rvalid_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;

    logic              b_elig;
    logic              a_win;
    logic              b_win;
    logic              accept;
    logic [ADDR_W-1:0] b_addr;

    // B may issue only if the output buffer will have room at the end of this cycle.
    assign b_elig = (state_q == S_RUN) && (issued_q < len_q) && (!dump_valid_q || i_dump_ready);
    assign b_addr = base_q + issued_q[ADDR_W-1:0];
    assign accept = dump_valid_q && i_dump_ready;

`ifdef DATA_MEM_ARB_RR_EN
    // Set when B won the most recent contended cycle; resets to B so A wins first.
    logic last_b_q, last_b_d;

    assign a_win = i_a_req && i_rst && (!b_elig || last_b_q);
    assign b_win = b_elig && !a_win;

    always_comb begin
        last_b_d = last_b_q;
        if (i_a_req && b_elig) begin
            last_b_d = b_win;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            last_b_q <= 1'b1;
        end else begin
            last_b_q <= last_b_d;
        end
    end
`else
    assign a_win = i_a_req && i_rst;
    assign b_win = b_elig && !a_win;
`endif

    assign o_a_gnt = a_win;

    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_wr    = 1'b0;
        o_mem_rd    = 1'b0;
        if (a_win) begin
            o_mem_addr  = i_a_addr;
            o_mem_wdata = i_a_wr ? i_a_wdata : '0;
            o_mem_wr    = i_a_wr;
            o_mem_rd    = !i_a_wr;
        end else if (b_win) begin
            o_mem_addr = b_addr;
            o_mem_rd   = 1'b1;
        end
    end

    always_comb begin
        a_rvalid_d   = a_win && !i_a_wr;
        a_rdata_d    = (a_win && !i_a_wr) ? i_mem_rdata : a_rdata_q;
        dump_valid_d = b_win || (dump_valid_q && !i_dump_ready);
        dump_data_d  = b_win ? i_mem_rdata : dump_data_q;
        state_d      = state_q;
        base_d       = base_q;
        len_d        = len_q;
        issued_d     = issued_q + {{ADDR_W{1'b0}}, b_win};
        accepted_d   = accepted_q + {{ADDR_W{1'b0}}, accept};
        case (state_q)
            S_IDLE: begin
                if (i_dump_start) begin
                    base_d     = i_dump_base;
                    len_d      = i_dump_len;
                    issued_d   = '0;
                    accepted_d = '0;
                    state_d    = (i_dump_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (issued_q == len_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (accepted_q == len_q) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            len_q        <= '0;
            issued_q     <= '0;
            accepted_q   <= '0;
            dump_valid_q <= 1'b0;
            dump_data_q  <= '0;
            a_rvalid_q   <= 1'b0;
            a_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            len_q        <= len_d;
            issued_q     <= issued_d;
            accepted_q   <= accepted_d;
            dump_valid_q <= dump_valid_d;
            dump_data_q  <= dump_data_d;
            a_rvalid_q   <= a_rvalid_d;
            a_rdata_q    <= a_rdata_d;
        end
    end

    assign o_a_rvalid   = a_rvalid_q;
    assign o_a_rdata    = a_rdata_q;
    assign o_dump_valid = dump_valid_q;
    assign o_dump_data  = dump_data_q;
    assign o_dump_busy  = (state_q != S_IDLE);
    assign o_dump_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: shadow memory model, expected-response queues, negedge monitor.
module tb_data_mem_arbiter;

    logic        i_clk;
    logic        i_rst;
    logic        i_a_req;
    logic        i_a_wr;
    logic [9:0]  i_a_addr;
    logic [15:0] i_a_wdata;
    logic        o_a_gnt;
    logic        o_a_rvalid;
    logic [15:0] o_a_rdata;
    logic        i_dump_start;
    logic [9:0]  i_dump_base;
    logic [10:0] i_dump_len;
    logic [15:0] o_dump_data;
    logic        o_dump_valid;
    logic        i_dump_ready;
    logic        o_dump_busy;
    logic        o_dump_done;
    logic [9:0]  o_mem_addr;
    logic [15:0] o_mem_wdata;
    logic        o_mem_wr;
    logic        o_mem_rd;
    logic [15:0] i_mem_rdata;

    data_mem_arbiter #(.DATA_W(16), .ADDR_W(10)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_a_req(i_a_req), .i_a_wr(i_a_wr), .i_a_addr(i_a_addr), .i_a_wdata(i_a_wdata),
        .o_a_gnt(o_a_gnt), .o_a_rvalid(o_a_rvalid), .o_a_rdata(o_a_rdata),
        .i_dump_start(i_dump_start), .i_dump_base(i_dump_base), .i_dump_len(i_dump_len),
        .o_dump_data(o_dump_data), .o_dump_valid(o_dump_valid), .i_dump_ready(i_dump_ready),
        .o_dump_busy(o_dump_busy), .o_dump_done(o_dump_done),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wr(o_mem_wr),
        .o_mem_rd(o_mem_rd), .i_mem_rdata(i_mem_rdata)
    );

    typedef struct {
        logic [15:0] d;
        int          c;
    } a_exp_t;

    logic [15:0] mem [1024];
    logic [15:0] shadow [1024];
    a_exp_t      a_q [$];
    logic [15:0] dump_q [$];
    int          beat_cycs [$];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int beats = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int done_cyc = 0;
    int rd_cnt = 0;
    int wrrd_viol = 0;
    int ready_mode = 0;
    bit a_bg_en = 0;
    bit a_bg_busy = 0;

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    initial begin
        i_clk = 0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    // Memory: samples on the negedge inside the granted cycle.
    always @(negedge i_clk) begin
        if (o_mem_wr) mem[o_mem_addr] <= o_mem_wdata;
        if (o_mem_rd) i_mem_rdata <= mem[o_mem_addr];
    end

    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            case (ready_mode)
                0: i_dump_ready = 1'b1;
                1: i_dump_ready = ~i_dump_ready;
                default: i_dump_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops expectations whenever the DUT presents a response.
    initial begin
        bit          prev_stall = 0;
        bit          prev_done = 0;
        logic [15:0] prev_data = '0;
        a_exp_t      e;
        logic [15:0] dx;
        forever begin
            @(negedge i_clk);
            if (!i_rst) begin
                prev_stall = 0;
                prev_done = 0;
                continue;
            end
            if (o_mem_wr && o_mem_rd) wrrd_viol++;
            if (o_mem_rd) rd_cnt++;
            if (o_a_rvalid) begin
                if (a_q.size() == 0) begin
                    chk(0, "a_rvalid_unexpected", o_a_rdata, 0);
                end else begin
                    e = a_q.pop_front();
                    chk(o_a_rdata == e.d, "a_rdata", o_a_rdata, e.d);
                    chk(e.c == cyc - 1, "a_rvalid_latency", cyc - e.c, 1);
                end
            end else if (a_q.size() > 0 && a_q[0].c < cyc - 1) begin
                e = a_q.pop_front();
                chk(0, "a_rvalid_missing", 0, e.d);
            end
            if (prev_stall) begin
                chk(o_dump_valid && (o_dump_data == prev_data), "dump_hold", o_dump_data, prev_data);
            end
            if (o_dump_valid && i_dump_ready) begin
                beats++;
                beat_cycs.push_back(cyc);
                if (dump_q.size() == 0) begin
                    chk(0, "dump_beat_unexpected", o_dump_data, 0);
                end else begin
                    dx = dump_q.pop_front();
                    chk(o_dump_data == dx, "dump_data", o_dump_data, dx);
                end
            end
            if (prev_done) chk(!o_dump_busy, "busy_after_done", o_dump_busy, 0);
            if (o_dump_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = o_dump_valid && !i_dump_ready;
            prev_data = o_dump_data;
            prev_done = o_dump_done;
        end
    end

    task automatic a_access(input bit wr, input logic [9:0] addr, input logic [15:0] data,
                            output int waited);
        bit got = 0;
        waited = 0;
        @(posedge i_clk);
        #1;
        i_a_req = 1; i_a_wr = wr; i_a_addr = addr; i_a_wdata = data;
        for (int w = 0; w < 60 && !got; w++) begin
            @(negedge i_clk);
            if (o_a_gnt) begin
                got = 1;
                if (wr) shadow[addr] = data;
                else a_q.push_back('{shadow[addr], cyc});
            end else begin
                waited++;
                @(posedge i_clk);
                #1;
            end
        end
        if (!got) chk(0, "a_grant_timeout", 0, 1);
        @(posedge i_clk);
        #1;
        i_a_req = 0;
    endtask

    task automatic drive_start(input logic [9:0] base, input logic [10:0] len, input bit push);
        i_dump_start = 1; i_dump_base = base; i_dump_len = len;
        if (push) begin
            exp_done++;
            for (int i = 0; i < int'(len); i++) dump_q.push_back(shadow[(int'(base) + i) % 1024]);
        end
    endtask

    task automatic pulse_start(input logic [9:0] base, input logic [10:0] len, input bit push);
        @(posedge i_clk);
        #1;
        drive_start(base, len, push);
        @(posedge i_clk);
        #1;
        i_dump_start = 0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        if (done_cnt < target) chk(0, "done_timeout", done_cnt, target);
    endtask

    initial begin
        forever begin
            @(posedge i_clk);
            if (a_bg_en) begin
                int w;
                a_bg_busy = 1;
                repeat ($urandom_range(0, 3)) @(posedge i_clk);
                a_access(0, 10'($urandom_range(0, 1023)), 16'h0, w);
                a_bg_busy = 0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int b0;
        int r0;
        int sc;
        int gcnt;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 16'h0;
            shadow[i] = 16'h0;
        end
        i_mem_rdata = 0;
        i_rst = 0; i_a_req = 0; i_a_wr = 0; i_a_addr = 0; i_a_wdata = 0;
        i_dump_start = 0; i_dump_base = 0; i_dump_len = 0; i_dump_ready = 1;
        #12;
        chk({o_a_gnt, o_a_rvalid, o_a_rdata, o_dump_data, o_dump_valid, o_dump_busy, o_dump_done,
             o_mem_addr, o_mem_wdata, o_mem_wr, o_mem_rd} == '0, "reset_outputs", o_dump_busy, 0);
        #10 i_rst = 1;

        // A write then read back.
        a_access(1, 10'h005, 16'h1234, w);
        chk(w == 0, "a_write_gnt_wait", w, 0);
        a_access(0, 10'h005, 16'h0, w);
        chk(w == 0, "a_read_gnt_wait", w, 0);
        repeat (2) @(posedge i_clk);

        // Wrap-around dump at full throughput.
        a_access(1, 10'h3FE, 16'hAAAA, w);
        a_access(1, 10'h3FF, 16'hBBBB, w);
        a_access(1, 10'h000, 16'hCCCC, w);
        ready_mode = 0;
        beat_cycs.delete();
        pulse_start(10'h3FE, 11'd3, 1);
        wait_done(exp_done, 50);
        chk(beat_cycs.size() == 3, "wrap_beat_count", beat_cycs.size(), 3);
        if (beat_cycs.size() == 3) chk(beat_cycs[2] - beat_cycs[0] == 2, "wrap_throughput", beat_cycs[2] - beat_cycs[0], 2);
        repeat (3) @(posedge i_clk);
        chk(done_cnt == exp_done, "wrap_done_once", done_cnt, exp_done);

        // Backpressure with ready toggling.
        for (int i = 0; i < 4; i++) a_access(1, 10'(16 + i), 16'($urandom), w);
        ready_mode = 1;
        b0 = beats;
        pulse_start(10'd16, 11'd4, 1);
        wait_done(exp_done, 60);
        repeat (2) @(posedge i_clk);
        chk(beats - b0 == 4, "toggle_beat_count", beats - b0, 4);
        chk(dump_q.size() == 0, "toggle_drained", dump_q.size(), 0);
        ready_mode = 0;

        // A requesting every cycle during a 2-word dump.
        b0 = beats;
        gcnt = 0;
        @(posedge i_clk);
        #1;
        drive_start(10'd16, 11'd2, 1);
        i_a_req = 1; i_a_wr = 0; i_a_addr = 10'($urandom_range(0, 1023));
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            if (o_a_gnt) begin
                gcnt++;
                a_q.push_back('{shadow[i_a_addr], cyc});
            end
            @(posedge i_clk);
            #1;
            i_dump_start = 0;
            i_a_addr = 10'($urandom_range(0, 1023));
        end
        i_a_req = 0;
`ifdef DATA_MEM_ARB_RR_EN
        chk(beats - b0 == 2, "rr_dump_beats", beats - b0, 2);
        chk(gcnt == 6, "rr_a_grants", gcnt, 6);
`else
        chk(beats - b0 == 0, "starve_dump_beats", beats - b0, 0);
        chk(gcnt == 8, "starve_a_grants", gcnt, 8);
`endif
        wait_done(exp_done, 40);
        repeat (2) @(posedge i_clk);
        chk(beats - b0 == 2, "contend_total_beats", beats - b0, 2);

        // Zero-length dump: done without reads.
        r0 = rd_cnt;
        @(posedge i_clk);
        #1;
        sc = cyc;
        drive_start(10'd100, 11'd0, 1);
        @(posedge i_clk);
        #1;
        i_dump_start = 0;
        wait_done(exp_done, 10);
        chk(done_cyc - sc <= 2 && done_cyc > sc, "len0_done_latency", done_cyc - sc, 2);
        chk(rd_cnt == r0, "len0_no_reads", rd_cnt - r0, 0);

        // Start while busy is ignored.
        for (int i = 0; i < 6; i++) a_access(1, 10'(200 + i), 16'($urandom), w);
        b0 = beats;
        pulse_start(10'd200, 11'd6, 1);
        pulse_start(10'd500, 11'd3, 0);
        wait_done(exp_done, 60);
        repeat (4) @(posedge i_clk);
        chk(beats - b0 == 6, "busy_start_beats", beats - b0, 6);
        chk(done_cnt == exp_done, "busy_start_done", done_cnt, exp_done);

        // Reset after 2 of 5 beats.
        b0 = beats;
        pulse_start(10'd200, 11'd5, 1);
        for (int n = 0; n < 40 && beats < b0 + 2; n++) @(negedge i_clk);
        chk(beats == b0 + 2, "pre_reset_beats", beats - b0, 2);
        #2 i_rst = 0;
        #1;
        chk({o_a_gnt, o_a_rvalid, o_a_rdata, o_dump_data, o_dump_valid, o_dump_busy, o_dump_done,
             o_mem_wr, o_mem_rd} == '0, "reset_mid_dump", {o_dump_valid, o_dump_busy}, 0);
        dump_q.delete();
        a_q.delete();
        exp_done--;
        repeat (2) @(posedge i_clk);
        #3 i_rst = 1;
        chk(!o_dump_busy, "post_reset_idle", o_dump_busy, 0);
        b0 = beats;
        pulse_start(10'd201, 11'd3, 1);
        wait_done(exp_done, 40);
        repeat (2) @(posedge i_clk);
        chk(beats - b0 == 3, "post_reset_dump", beats - b0, 3);

        // Randomized dumps with background A reads and random backpressure.
        for (int i = 0; i < 16; i++) a_access(1, 10'($urandom_range(0, 1023)), 16'($urandom), w);
        ready_mode = 2;
        a_bg_en = 1;
        for (int k = 0; k < 8; k++) begin
            pulse_start(10'($urandom_range(0, 1023)), 11'($urandom_range(0, 12)), 1);
            wait_done(exp_done, 600);
            repeat (2) @(posedge i_clk);
        end
        a_bg_en = 0;
        for (int n = 0; n < 200 && a_bg_busy; n++) @(posedge i_clk);
        ready_mode = 0;
        repeat (4) @(posedge i_clk);

        chk(a_q.size() == 0, "a_queue_empty", a_q.size(), 0);
        chk(dump_q.size() == 0, "dump_queue_empty", dump_q.size(), 0);
        chk(done_cnt == exp_done, "done_pulse_count", done_cnt, exp_done);
        chk(wrrd_viol == 0, "wr_rd_exclusive", wrrd_viol, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port BIP data memory between two requesters: port A (CPU load/store) and an internal dump sequencer (port B).
- The dump sequencer streams a contiguous address range out over a valid/ready interface for the debug UART.
- Sits between the CPU/debug unit and the data memory.
- Drives the memory's addr/data/wr/rd pins, never asserts wr and rd together, and registers read data so requesters never sample the memory's negedge-updated output directly.

Parameters:
- DATA_W, 16, memory word width.
- ADDR_W, 10, memory address width (1024 words).

Ports:
- i_clk  in  1  clock; all logic on posedge.
- i_rst  in  1  asynchronous active-low reset.
- i_a_req  in  1  port A access request; held until granted.
- i_a_wr  in  1  port A: 1 = write, 0 = read.
- i_a_addr  in  ADDR_W  port A address.
- i_a_wdata  in  DATA_W  port A write data.
- o_a_gnt  out  1  combinational grant; the access executes this cycle.
- o_a_rvalid  out  1  registered; high one cycle after a granted read.
- o_a_rdata  out  DATA_W  registered read data, valid while o_a_rvalid is high.
- i_dump_start  in  1  one-cycle pulse; starts a dump.
- i_dump_base  in  ADDR_W  first dump address, sampled on start.
- i_dump_len  in  ADDR_W+1  word count (0..2^ADDR_W), sampled on start.
- o_dump_data  out  DATA_W  dump stream data.
- o_dump_valid  out  1  dump stream valid.
- i_dump_ready  in  1  dump stream ready.
- o_dump_busy  out  1  dump in progress.
- o_dump_done  out  1  one-cycle pulse when the last word is accepted.
- o_mem_addr  out  ADDR_W  to memory i_addr.
- o_mem_wdata  out  DATA_W  to memory i_data.
- o_mem_wr  out  1  to memory i_wr.
- o_mem_rd  out  1  to memory i_rd.
- i_mem_rdata  in  DATA_W  from memory o_data.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, buffer empty. Reset mid-dump aborts the dump with no done pulse.
- Memory contract: memory samples on the negedge inside the granted cycle T. Read data is stable by the posedge ending T and is captured on that edge. Read latency is 1 cycle.
- Memory pins are combinational from the winner. With no winner, o_mem_wr = o_mem_rd = 0 and addr/wdata = 0. Never wr && rd.
- Port A grant: o_a_gnt = i_a_req && A wins.
  - Granted write: o_mem_wr = 1; no rvalid.
  - Granted read: o_mem_rd = 1; o_a_rvalid = 1 in T+1 with o_a_rdata = the word read.
  - o_a_rdata holds its value until the next A read.
- Port B issue condition: state RUN && issued < len && (!o_dump_valid || i_dump_ready) && B wins.
  - On issue: read at base+issued, modulo 2^ADDR_W (wraps at the top of memory); issued increments.
  - The one-entry output buffer loads at the end of T: o_dump_valid = 1 in T+1.
  - A beat is accepted when valid && ready. Accept and reload in the same edge are allowed, giving 1 word/cycle throughput.
- Dump FSM states:
  - IDLE: start → RUN (sample base and len; issued = accepted = 0). If len == 0: IDLE → DONE directly, no reads.
  - RUN: when issued == len → DRAIN.
  - DRAIN: when accepted == len → DONE.
  - DONE: o_dump_done = 1 for one cycle → IDLE.
- o_dump_busy = 1 in RUN, DRAIN and DONE.
- Start while busy is ignored.
- Arbitration (default): A has fixed priority. B issues only in cycles with !i_a_req.

Optional Feature:
- Macro: DATA_MEM_ARB_RR_EN.
- Defined:
  - On contention (A requesting and B eligible), the port not granted in the most recent contended cycle wins.
  - The last-winner flag resets to B, so A wins the first contention.
  - This bounds A's wait to 1 cycle during a dump.
- Undefined: fixed A priority as above; B can be starved indefinitely.

Test Plan:
- A write 0x1234 @0x005, then A read @0x005 → o_a_gnt high both cycles; in the cycle after the read, o_a_rvalid = 1 and o_a_rdata = 0x1234; o_mem_wr and o_mem_rd never both 1.
- Preload 0x3FE=0xAAAA, 0x3FF=0xBBBB, 0x000=0xCCCC; dump base=0x3FE, len=3, ready=1 → stream AAAA, BBBB, CCCC on consecutive cycles (wrap to 0x000), o_dump_done pulse once, busy drops the cycle after.
- Dump len=4 with i_dump_ready toggling 1/0 → exactly 4 beats, no duplicates or drops, data stable while valid && !ready.
- A requesting every cycle during a 2-word dump: without the macro, zero dump beats until A drops; with DATA_MEM_ARB_RR_EN, grants alternate A, B, A, B and the dump completes in ≤5 cycles.
- len=0 start → o_dump_done pulse 2 cycles later, no memory reads; start asserted while busy → ignored, original dump completes unchanged.
- Assert i_rst low mid-dump (after 2 of 5 beats) → all outputs 0 immediately; after release, state IDLE and a new dump runs correctly.
